ysyx_sq: RTL and testbench

//  Committed store queue sitting directly downstream of the ROB commit port.

---
 rtl/ysyx_sq_pkg.sv | 12 +
 rtl/ysyx_sq_if.sv | 28 ++
 rtl/ysyx_sq.sv | 79 +++++++
 tb/tb_ysyx_sq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_sq_pkg.sv
// ysyx_sq_pkg: store-queue sizing, commit size codes and the size-to-strobe helper
package ysyx_sq_pkg;
  localparam int SQ_DEPTH = 4;
  localparam int SQ_XLEN = 32;
  localparam logic [4:0] WSTRB_SB = 5'd1;
  localparam logic [4:0] WSTRB_SH = 5'd2;
  localparam logic [4:0] WSTRB_SW = 5'd3;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} sq_state_e;
  function automatic logic [3:0] size_strb(input logic [4:0] alu);
    return alu == WSTRB_SB ? 4'b0001 : alu == WSTRB_SH ? 4'b0011 : alu == WSTRB_SW ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/ysyx_sq_if.sv
// ysyx_sq_if: commit, load-check and data-memory write bus signals of the store queue
interface ysyx_sq_if #(parameter int XLEN = ysyx_sq_pkg::SQ_XLEN);
  logic            cm_valid;
  logic            cm_store;
  logic [4:0]      cm_alu;
  logic [XLEN-1:0] cm_waddr;
  logic [XLEN-1:0] cm_wdata;
  logic [XLEN-1:0] cm_pc;
  logic            sq_ready;
  logic            sq_empty;
  logic [XLEN-1:0] ld_addr;
  logic            ld_conflict;
  logic            dm_req_valid;
  logic            dm_req_ready;
  logic [XLEN-1:0] dm_req_addr;
  logic [XLEN-1:0] dm_req_wdata;
  logic [3:0]      dm_req_wstrb;
  logic [XLEN-1:0] dm_req_pc;
  logic            dm_resp_valid;
  modport master (
    output cm_valid, cm_store, cm_alu, cm_waddr, cm_wdata, cm_pc, ld_addr, dm_req_ready, dm_resp_valid,
    input  sq_ready, sq_empty, ld_conflict, dm_req_valid, dm_req_addr, dm_req_wdata, dm_req_wstrb, dm_req_pc
  );
  modport slave (
    input  cm_valid, cm_store, cm_alu, cm_waddr, cm_wdata, cm_pc, ld_addr, dm_req_ready, dm_resp_valid,
    output sq_ready, sq_empty, ld_conflict, dm_req_valid, dm_req_addr, dm_req_wdata, dm_req_wstrb, dm_req_pc
  );
endinterface

// File: rtl/ysyx_sq.sv
// ysyx_sq: committed store queue draining retired stores in FIFO order to the data-memory bus
module ysyx_sq
  import ysyx_sq_pkg::*;
#(
  parameter int SQ_SIZE = SQ_DEPTH,
  parameter int XLEN    = SQ_XLEN
) (
  input logic      clk,
  input logic      rst_n,
  ysyx_sq_if.slave sq
);
  localparam int PW = $clog2(SQ_SIZE);
  localparam int CW = $clog2(SQ_SIZE + 1);
  logic [XLEN-1:0] addr_q [SQ_SIZE];
  logic [XLEN-1:0] data_q [SQ_SIZE];
  logic [XLEN-1:0] pc_q   [SQ_SIZE];
  logic [4:0]      alu_q  [SQ_SIZE];
  logic [SQ_SIZE-1:0] valid_q, valid_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  sq_state_e state_q, state_d;
  logic push, pop, conflict;
  logic [XLEN-1:0] h_addr;
  logic [1:0] h_off;
  assign sq.sq_ready = count_q != CW'(SQ_SIZE);
  assign sq.sq_empty = count_q == '0 && state_q == S_IDLE;
  assign push = sq.cm_valid && sq.cm_store && sq.sq_ready;
  assign pop = state_q == S_RESP && sq.dm_resp_valid;
  assign h_addr = addr_q[head_q];
  assign h_off = h_addr[1:0];
  assign sq.dm_req_valid = state_q == S_REQ;
  assign sq.dm_req_addr = sq.dm_req_valid ? {h_addr[XLEN-1:2], 2'b00} : '0;
  assign sq.dm_req_wdata = sq.dm_req_valid ? data_q[head_q] << {h_off, 3'b000} : '0;
  assign sq.dm_req_wstrb = sq.dm_req_valid ? size_strb(alu_q[head_q]) << h_off : '0;
  assign sq.dm_req_pc = sq.dm_req_valid ? pc_q[head_q] : '0;
  assign sq.ld_conflict = conflict;
  // the in-flight head stays valid until its response, so it still blocks loads
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < SQ_SIZE; i++)
      conflict = conflict | (valid_q[i] && ((addr_q[i] ^ sq.ld_addr) >> 2) == '0);
  end
  always_comb begin
    state_d = state_q == S_IDLE ? (valid_q[head_q] ? S_REQ : S_IDLE) :
              state_q == S_REQ  ? (sq.dm_req_ready ? S_RESP : S_REQ) :
                                  (sq.dm_resp_valid ? S_IDLE : S_RESP);
    valid_d = valid_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= sq.cm_waddr;
      data_q[tail_q] <= sq.cm_wdata;
      pc_q[tail_q] <= sq.cm_pc;
      alu_q[tail_q] <= sq.cm_alu;
    end
  end
  a_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n) push |-> !valid_q[tail_q]);
  a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> count_q != '0);
endmodule

// File: tb/tb_ysyx_sq.sv
// tb_ysyx_sq: directed scenarios plus a randomized run against a queue-based store model
module tb_ysyx_sq;
  import ysyx_sq_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  ysyx_sq_if sq();
  ysyx_sq dut (.clk(clk), .rst_n(rst_n), .sq(sq));
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  function automatic txn_t expect_txn(input logic [4:0] alu, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    int nb;
    int off;
    nb = alu == WSTRB_SB ? 1 : alu == WSTRB_SH ? 2 : 4;
    off = int'(a % 4);
    t.addr = a - 32'(off);
    t.wstrb = 4'(((1 << nb) - 1) << off);
    t.wdata = d << (8 * off);
    return t;
  endfunction

  task automatic idle();
    sq.cm_valid = 0; sq.cm_store = 0; sq.cm_alu = '0; sq.cm_waddr = '0; sq.cm_wdata = '0;
    sq.cm_pc = '0; sq.ld_addr = '0; sq.dm_req_ready = 0; sq.dm_resp_valid = 0;
  endtask

  task automatic drive_push(input logic [4:0] alu, input logic [31:0] a, input logic [31:0] d);
    sq.cm_valid = 1; sq.cm_store = 1; sq.cm_alu = alu; sq.cm_waddr = a; sq.cm_wdata = d; sq.cm_pc = a ^ 32'h1000;
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++)
      if (sq.dm_req_valid) ok = 1; else @(negedge clk);
  endtask

  task automatic serve(output txn_t t, output bit ok);
    wait_req(ok);
    t.addr = sq.dm_req_addr; t.wdata = sq.dm_req_wdata; t.wstrb = sq.dm_req_wstrb;
    sq.dm_req_ready = 1;
    @(negedge clk);
    sq.dm_req_ready = 0; sq.dm_resp_valid = 1;
    @(negedge clk);
    sq.dm_resp_valid = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    tests++; if (sq.sq_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", sq.sq_ready); end
    tests++; if (sq.sq_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", sq.sq_empty); end
    tests++; if (sq.dm_req_valid !== 1'b0 || sq.ld_conflict !== 1'b0) begin
      fails++; $display("FAIL reset_valid_conf got %b/%b want 0/0", sq.dm_req_valid, sq.ld_conflict); end
    tests++; if ({sq.dm_req_addr, sq.dm_req_wdata, sq.dm_req_wstrb} !== 68'h0) begin
      fails++; $display("FAIL reset_fields got %h %h %b want 0", sq.dm_req_addr, sq.dm_req_wdata, sq.dm_req_wstrb); end
  endtask

  task automatic test_single_sw();
    txn_t e;
    e = expect_txn(WSTRB_SW, 32'h8000_0004, 32'hDEAD_BEEF);
    @(negedge clk);
    drive_push(WSTRB_SW, 32'h8000_0004, 32'hDEAD_BEEF);
    sq.dm_req_ready = 1;
    @(negedge clk);
    sq.cm_valid = 0;
    tests++; if (sq.dm_req_valid !== 1'b0 || sq.sq_empty !== 1'b0) begin
      fails++; $display("FAIL sw_n1 valid/empty got %b/%b want 0/0", sq.dm_req_valid, sq.sq_empty); end
    @(negedge clk);
    tests++; if (sq.dm_req_valid !== 1'b1) begin fails++; $display("FAIL sw_latency valid got %b want 1", sq.dm_req_valid); end
    tests++; if (sq.dm_req_addr !== e.addr) begin fails++; $display("FAIL sw_addr got %h want %h", sq.dm_req_addr, e.addr); end
    tests++; if (sq.dm_req_wstrb !== e.wstrb || sq.dm_req_wdata !== e.wdata) begin
      fails++; $display("FAIL sw_data got %b %h want %b %h", sq.dm_req_wstrb, sq.dm_req_wdata, e.wstrb, e.wdata); end
    @(negedge clk);
    sq.dm_req_ready = 0; sq.dm_resp_valid = 1;
    tests++; if (sq.dm_req_valid !== 1'b0 || sq.sq_empty !== 1'b0) begin
      fails++; $display("FAIL sw_resp valid/empty got %b/%b want 0/0", sq.dm_req_valid, sq.sq_empty); end
    @(negedge clk);
    sq.dm_resp_valid = 0;
    tests++; if (sq.sq_empty !== 1'b1) begin fails++; $display("FAIL sw_done empty got %b want 1", sq.sq_empty); end
  endtask

  task automatic test_sb();
    txn_t t;
    bit ok;
    @(negedge clk);
    drive_push(WSTRB_SB, 32'h8000_0003, 32'h0000_00AB);
    @(negedge clk);
    sq.cm_valid = 0;
    serve(t, ok);
    tests++; if (!ok || t.addr !== 32'h8000_0000) begin fails++; $display("FAIL sb_addr got %h ok=%0d want 80000000", t.addr, ok); end
    tests++; if (t.wstrb !== 4'b1000 || t.wdata !== 32'hAB00_0000) begin
      fails++; $display("FAIL sb_lane got %b %h want 1000 ab000000", t.wstrb, t.wdata); end
    tests++; if (sq.sq_empty !== 1'b1) begin fails++; $display("FAIL sb_empty got %b want 1", sq.sq_empty); end
  endtask

  task automatic test_full();
    txn_t t;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_push(WSTRB_SW, 32'h8000_0100 + 32'(i * 4), 32'(i));
    end
    @(negedge clk);
    sq.cm_valid = 0;
    tests++; if (sq.sq_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", sq.sq_ready); end
    tests++; if (sq.dm_req_valid !== 1'b1 || sq.dm_req_addr !== 32'h8000_0100) begin
      fails++; $display("FAIL full_head got %b %h want 1 80000100", sq.dm_req_valid, sq.dm_req_addr); end
    sq.dm_req_ready = 1;
    @(negedge clk);
    sq.dm_req_ready = 0; sq.dm_resp_valid = 1;
    drive_push(WSTRB_SW, 32'h8000_0200, 32'h55);
    tests++; if (sq.sq_ready !== 1'b0) begin fails++; $display("FAIL full_popcycle_ready got %b want 0", sq.sq_ready); end
    @(negedge clk);
    sq.dm_resp_valid = 0; sq.cm_valid = 0;
    tests++; if (sq.sq_ready !== 1'b1) begin fails++; $display("FAIL full_afterpop_ready got %b want 1", sq.sq_ready); end
    for (int i = 1; i < 4; i++) begin
      serve(t, ok);
      tests++; if (!ok || t.addr !== 32'h8000_0100 + 32'(i * 4)) begin
        fails++; $display("FAIL full_order%0d got %h ok=%0d want %h", i, t.addr, ok, 32'h8000_0100 + 32'(i * 4)); end
    end
    tests++; if (sq.sq_empty !== 1'b1) begin fails++; $display("FAIL full_5th_rejected empty got %b want 1", sq.sq_empty); end
  endtask

  task automatic test_conflict();
    bit ok;
    @(negedge clk);
    drive_push(WSTRB_SH, 32'h8000_0010, 32'h0000_1234);
    sq.ld_addr = 32'h8000_0012;
    #1;
    tests++; if (sq.ld_conflict !== 1'b0) begin fails++; $display("FAIL conf_before got %b want 0", sq.ld_conflict); end
    @(negedge clk);
    sq.cm_valid = 0;
    #1;
    tests++; if (sq.ld_conflict !== 1'b1) begin fails++; $display("FAIL conf_same_word got %b want 1", sq.ld_conflict); end
    sq.ld_addr = 32'h8000_0014;
    #1;
    tests++; if (sq.ld_conflict !== 1'b0) begin fails++; $display("FAIL conf_next_word got %b want 0", sq.ld_conflict); end
    sq.ld_addr = 32'h8000_0012;
    wait_req(ok);
    #1;
    tests++; if (!ok || sq.dm_req_wstrb !== 4'b0011 || sq.dm_req_wdata !== 32'h0000_1234 || sq.ld_conflict !== 1'b1) begin
      fails++; $display("FAIL conf_req got ok=%0d %b %h conf=%b want 0011 00001234 1", ok, sq.dm_req_wstrb, sq.dm_req_wdata, sq.ld_conflict); end
    sq.dm_req_ready = 1;
    @(negedge clk);
    sq.dm_req_ready = 0;
    repeat (2) begin
      #1;
      tests++; if (sq.ld_conflict !== 1'b1) begin fails++; $display("FAIL conf_inflight got %b want 1", sq.ld_conflict); end
      @(negedge clk);
    end
    sq.dm_resp_valid = 1;
    #1;
    tests++; if (sq.ld_conflict !== 1'b1) begin fails++; $display("FAIL conf_resp_cycle got %b want 1", sq.ld_conflict); end
    @(negedge clk);
    sq.dm_resp_valid = 0;
    #1;
    tests++; if (sq.ld_conflict !== 1'b0) begin fails++; $display("FAIL conf_after_pop got %b want 0", sq.ld_conflict); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_push(WSTRB_SW, 32'h8000_0300 + 32'(i * 4), 32'hA0 + 32'(i));
    end
    @(negedge clk);
    sq.cm_valid = 0;
    wait_req(ok);
    sq.dm_req_ready = 1;
    @(negedge clk);
    sq.dm_req_ready = 0;
    tests++; if (!ok || sq.sq_empty !== 1'b0 || sq.dm_req_valid !== 1'b0) begin
      fails++; $display("FAIL mid_resp got ok=%0d empty=%b valid=%b want 1/0/0", ok, sq.sq_empty, sq.dm_req_valid); end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    sq.ld_addr = 32'h8000_0304;
    #1;
    tests++; if (sq.sq_empty !== 1'b1 || sq.sq_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset empty/ready got %b/%b want 1/1", sq.sq_empty, sq.sq_ready); end
    tests++; if (sq.ld_conflict !== 1'b0 || sq.dm_req_valid !== 1'b0) begin
      fails++; $display("FAIL mid_reset conf/valid got %b/%b want 0/0", sq.ld_conflict, sq.dm_req_valid); end
    repeat (4) @(negedge clk);
    tests++; if (sq.dm_req_valid !== 1'b0 || sq.sq_empty !== 1'b1) begin
      fails++; $display("FAIL mid_dropped valid/empty got %b/%b want 0/1", sq.dm_req_valid, sq.sq_empty); end
  endtask

  task automatic test_random();
    txn_t q[$];
    txn_t e;
    bit waiting;
    bit exp_conf;
    bit acc;
    int delay;
    int stall;
    int k;
    int off;
    logic [4:0] alu;
    logic [31:0] a;
    waiting = 0; delay = 0; stall = 0;
    idle();
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      k = $urandom_range(0, 2);
      alu = k == 0 ? WSTRB_SB : k == 1 ? WSTRB_SH : WSTRB_SW;
      off = k == 0 ? $urandom_range(0, 3) : k == 1 ? 2 * $urandom_range(0, 1) : 0;
      a = 32'h8000_0000 + 32'(4 * $urandom_range(0, 15) + off);
      drive_push(alu, a, $urandom);
      sq.cm_valid = cyc < 600 && $urandom_range(0, 1) == 1;
      sq.cm_store = $urandom_range(0, 3) != 0;
      sq.ld_addr = 32'h8000_0000 + 32'($urandom_range(0, 71));
      sq.dm_req_ready = cyc >= 600 || $urandom_range(0, 1) == 1;
      sq.dm_resp_valid = waiting && delay == 0;
      #1;
      exp_conf = 0;
      foreach (q[i]) if (q[i].addr[31:2] == sq.ld_addr[31:2]) exp_conf = 1;
      tests++; if (sq.sq_ready !== (q.size() != 4)) begin fails++; $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, sq.sq_ready, q.size() != 4); end
      tests++; if (sq.sq_empty !== (q.size() == 0)) begin fails++; $display("FAIL rnd_empty cyc=%0d got %b want %b", cyc, sq.sq_empty, q.size() == 0); end
      tests++; if (sq.ld_conflict !== exp_conf) begin fails++; $display("FAIL rnd_conflict cyc=%0d got %b want %b", cyc, sq.ld_conflict, exp_conf); end
      if (sq.dm_req_valid) begin
        tests++;
        if (waiting || q.size() == 0 || sq.dm_req_addr !== q[0].addr || sq.dm_req_wdata !== q[0].wdata || sq.dm_req_wstrb !== q[0].wstrb) begin
          fails++;
          $display("FAIL rnd_req cyc=%0d got %h %h %b want %h %h %b", cyc, sq.dm_req_addr, sq.dm_req_wdata, sq.dm_req_wstrb,
                   q.size() ? q[0].addr : 32'h0, q.size() ? q[0].wdata : 32'h0, q.size() ? q[0].wstrb : 4'h0);
        end
      end
      stall = (q.size() > 0 && !waiting && !sq.dm_req_valid) ? stall + 1 : 0;
      tests++; if (stall > 3) begin fails++; $display("FAIL rnd_stall cyc=%0d got %0d idle cycles want <=3", cyc, stall); end
      acc = sq.cm_valid && sq.cm_store && q.size() != 4;
      if (sq.dm_resp_valid) begin
        void'(q.pop_front());
        waiting = 0;
      end else if (waiting) delay--;
      if (sq.dm_req_valid && sq.dm_req_ready) begin
        waiting = 1;
        delay = $urandom_range(0, 3);
      end
      if (acc) begin
        e = expect_txn(alu, a, sq.cm_wdata);
        q.push_back(e);
      end
    end
    @(negedge clk);
    idle();
    #1;
    tests++; if (q.size() != 0 || sq.sq_empty !== 1'b1) begin
      fails++; $display("FAIL rnd_drain got model=%0d empty=%b want 0/1", q.size(), sq.sq_empty); end
  endtask

  initial begin
    idle();
    test_reset();
    test_single_sw();
    test_sb();
    test_full();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
